branch_dir_target_unit: RTL and testbench

//  Fetch-stage direction and target predictor. It holds three structures:
//   - BTB: direct-mapped branch target buffer.
//   - GBP: gshare global predictor.
//   - LBP: two-level local predictor.

---
 rtl/branch_dir_target_unit_if.sv | 39 +++
 rtl/branch_dir_target_unit.sv | 121 ++++++++++++
 tb/tb_branch_dir_target_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/branch_dir_target_unit_if.sv
// Fetch/decode-side bundle for the branch direction and target predictor.
// Latency: none. The interface only carries signals.
// Backpressure: none. The stall_i input freezes the predictor state.
//
// Signals, named from the predictor's side:
//   stall_i        pipeline stall; predictor state holds while high
//   if_pc_i        PC in fetch; all predictions are made for this PC
//   id_pc_i        PC in decode; the resolved branch trains this PC
//   alt_address_i  resolved taken-target of the decode branch
//   is_branch_i    the decode instruction is a conditional branch or jump
//   is_taken_i     resolved direction of the decode branch
//   btb_hit_o      BTB holds a valid, tag-matching entry for if_pc_i
//   btb_alt_pc_o   stored target for if_pc_i (meaningless when btb_hit_o=0)
//   gbp_pred_o     gshare taken prediction for if_pc_i
//   lbp_pred_o     local two-level taken prediction for if_pc_i
interface branch_dir_target_unit_if;
  logic        stall_i;
  logic [31:0] if_pc_i;
  logic [31:0] id_pc_i;
  logic [31:0] alt_address_i;
  logic        is_branch_i;
  logic        is_taken_i;
  logic        btb_hit_o;
  logic [31:0] btb_alt_pc_o;
  logic        gbp_pred_o;
  logic        lbp_pred_o;

  // Predictor side
  modport slave (
    input  stall_i, if_pc_i, id_pc_i, alt_address_i, is_branch_i, is_taken_i,
    output btb_hit_o, btb_alt_pc_o, gbp_pred_o, lbp_pred_o
  );

  // Pipeline side
  modport master (
    output stall_i, if_pc_i, id_pc_i, alt_address_i, is_branch_i, is_taken_i,
    input  btb_hit_o, btb_alt_pc_o, gbp_pred_o, lbp_pred_o
  );
endinterface

// File: rtl/branch_dir_target_unit.sv
// Fetch-stage predictor with three parts: a direct-mapped BTB, a gshare predictor and a two-level local predictor.
// Latency: predictions are combinational from if_pc_i. Training from decode is visible the cycle after the edge.
// Backpressure: none. While stall_i is high, every piece of state holds.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset. It clears BTB valids, GHR and LHT, and sets every counter to weakly not-taken.
//   bus    branch_dir_target_unit_if.slave (fetch PC, decode training inputs, prediction outputs)
module branch_dir_target_unit #(
  parameter int BTB_IDX_W = 6,
  parameter int GHR_W     = 8,
  parameter int LHT_IDX_W = 6,
  parameter int LHR_W     = 6
) (
  input logic                      clk,
  input logic                      reset,
  branch_dir_target_unit_if.slave  bus
);

  localparam int BTB_N  = 1 << BTB_IDX_W;
  localparam int TAG_W  = 30 - BTB_IDX_W;
  localparam int GPHT_N = 1 << GHR_W;
  localparam int LHT_N  = 1 << LHT_IDX_W;
  localparam int LPHT_N = 1 << LHR_W;

  // State
  logic                 btb_vld_q [BTB_N];
  logic [TAG_W-1:0]     btb_tag_q [BTB_N];
  logic [31:0]          btb_tgt_q [BTB_N];
  logic [1:0]           gpht_q    [GPHT_N];
  logic [GHR_W-1:0]     ghr_q;
  logic [LHR_W-1:0]     lht_q     [LHT_N];
  logic [1:0]           lpht_q    [LPHT_N];

  // Two-bit saturating counter step. It never wraps past 0 or 3.
  function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
    logic [1:0] r;
    r = c;
    if (up) begin
      if (c != 2'b11) r = c + 2'd1;
    end else begin
      if (c != 2'b00) r = c - 2'd1;
    end
    return r;
  endfunction

  // ---------------- Fetch-side reads ----------------
  logic [BTB_IDX_W-1:0] btb_ridx;
  logic [TAG_W-1:0]     rd_tag;
  logic [GHR_W-1:0]     gbp_ridx;
  logic [LHT_IDX_W-1:0] lht_ridx;
  logic [LHR_W-1:0]     lhist_r;

  assign btb_ridx = bus.if_pc_i[BTB_IDX_W+1:2];
  assign rd_tag   = bus.if_pc_i[31:BTB_IDX_W+2];
  assign gbp_ridx = bus.if_pc_i[GHR_W+1:2] ^ ghr_q;
  assign lht_ridx = bus.if_pc_i[LHT_IDX_W+1:2];
  assign lhist_r  = lht_q[lht_ridx];

  assign bus.btb_hit_o    = btb_vld_q[btb_ridx] && (btb_tag_q[btb_ridx] == rd_tag);
  assign bus.btb_alt_pc_o = btb_tgt_q[btb_ridx];
  assign bus.gbp_pred_o   = gpht_q[gbp_ridx][1];
  assign bus.lbp_pred_o   = lpht_q[lhist_r][1];

  // Bits [1:0] of both PCs carry no information for indexing or tagging.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bus.if_pc_i[1:0], bus.id_pc_i[1:0]};

  // ---------------- Decode-side training ----------------
  logic                 upd;
  logic                 taken;
  logic [BTB_IDX_W-1:0] btb_widx;
  logic [TAG_W-1:0]     wr_tag;
  logic [GHR_W-1:0]     gbp_widx;
  logic [LHT_IDX_W-1:0] lht_widx;
  logic [LHR_W-1:0]     lhist_w;
  logic [GHR_W-1:0]     ghr_d;
  logic [LHR_W-1:0]     lhist_d;
  logic [1:0]           gctr_d;
  logic [1:0]           lctr_d;

  assign upd      = !bus.stall_i && bus.is_branch_i;
  assign taken    = bus.is_taken_i;
  assign btb_widx = bus.id_pc_i[BTB_IDX_W+1:2];
  assign wr_tag   = bus.id_pc_i[31:BTB_IDX_W+2];
  // The index uses the GHR before the shift. Gshare reads and writes agree on this.
  assign gbp_widx = bus.id_pc_i[GHR_W+1:2] ^ ghr_q;
  assign lht_widx = bus.id_pc_i[LHT_IDX_W+1:2];
  assign lhist_w  = lht_q[lht_widx];

  assign ghr_d    = {ghr_q[GHR_W-2:0], taken};
  assign lhist_d  = {lhist_w[LHR_W-2:0], taken};
  assign gctr_d   = sat2(gpht_q[gbp_widx], taken);
  assign lctr_d   = sat2(lpht_q[lhist_w], taken);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ghr_q <= '0;
      for (int i = 0; i < BTB_N; i++)  btb_vld_q[i] <= 1'b0;
      for (int i = 0; i < GPHT_N; i++) gpht_q[i]    <= 2'b01;
      for (int i = 0; i < LHT_N; i++)  lht_q[i]     <= '0;
      for (int i = 0; i < LPHT_N; i++) lpht_q[i]    <= 2'b01;
    end else if (upd) begin
      ghr_q              <= ghr_d;
      gpht_q[gbp_widx]   <= gctr_d;
      lpht_q[lhist_w]    <= lctr_d;
      lht_q[lht_widx]    <= lhist_d;
      // Not-taken branches never allocate and never invalidate.
      if (taken) btb_vld_q[btb_widx] <= 1'b1;
    end
  end

  // The tag and target payload needs no reset, because the valid bit qualifies it.
  always_ff @(posedge clk) begin
    if (reset && upd && taken) begin
      btb_tag_q[btb_widx] <= wr_tag;
      btb_tgt_q[btb_widx] <= bus.alt_address_i;
    end
  end

endmodule

// File: tb/tb_branch_dir_target_unit.sv
module tb_branch_dir_target_unit;

  localparam logic [1:0] OP_STEP = 2'd0;
  localparam logic [1:0] OP_RST  = 2'd1;

  typedef struct {
    logic [1:0]  op;
    logic        stall;
    logic        br;
    logic        tk;
    logic [31:0] id_pc;
    logic [31:0] alt;
    logic [31:0] if_pc;
    logic        chk;
    logic        e_hit;
    logic [31:0] e_tgt;
    logic        e_gbp;
    logic        e_lbp;
  } vec_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  vec_t tbl[$];
  vec_t sbq[$];

  branch_dir_target_unit_if bif();

  branch_dir_target_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [1:0] op, input logic st, input logic br, input logic tk,
                              input logic [31:0] id_pc, input logic [31:0] alt, input logic [31:0] if_pc,
                              input logic chk, input logic e_hit, input logic [31:0] e_tgt,
                              input logic e_gbp, input logic e_lbp);
    vec_t v;
    v.op = op; v.stall = st; v.br = br; v.tk = tk;
    v.id_pc = id_pc; v.alt = alt; v.if_pc = if_pc;
    v.chk = chk; v.e_hit = e_hit; v.e_tgt = e_tgt; v.e_gbp = e_gbp; v.e_lbp = e_lbp;
    return v;
  endfunction

  // A read-only vector: no training, only a check of the predictions for if_pc.
  function automatic vec_t rd(input logic [31:0] if_pc, input logic e_hit, input logic [31:0] e_tgt,
                              input logic e_gbp, input logic e_lbp);
    return mk(OP_STEP, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, if_pc, 1'b1, e_hit, e_tgt, e_gbp, e_lbp);
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bif.stall_i = 1'b0; bif.is_branch_i = 1'b0; bif.is_taken_i = 1'b0;
    bif.id_pc_i = 32'h0; bif.alt_address_i = 32'h0;
  endtask

  // Inputs are driven just after the falling edge, and outputs are sampled 2 ns later.
  // Any training happens at the next rising edge, so each check sees the state before the update.
  task automatic run_vec(input vec_t v, input int n);
    vec_t e;
    @(negedge clk);
    if (v.op == OP_RST) begin
      idle();
      #1 reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
    end else begin
      bif.stall_i = v.stall; bif.is_branch_i = v.br; bif.is_taken_i = v.tk;
      bif.id_pc_i = v.id_pc; bif.alt_address_i = v.alt; bif.if_pc_i = v.if_pc;
      if (v.chk) sbq.push_back(v);
      #2;
      if (v.chk) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL v%0d.sbq: got empty queue, expected an entry", n);
        end else begin
          e = sbq.pop_front();
          cmp($sformatf("v%0d.hit", n), {31'h0, bif.btb_hit_o}, {31'h0, e.e_hit});
          if (e.e_hit) cmp($sformatf("v%0d.tgt", n), bif.btb_alt_pc_o, e.e_tgt);
          cmp($sformatf("v%0d.gbp", n), {31'h0, bif.gbp_pred_o}, {31'h0, e.e_gbp});
          cmp($sformatf("v%0d.lbp", n), {31'h0, bif.lbp_pred_o}, {31'h0, e.e_lbp});
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    idle();
    bif.if_pc_i = 32'h0;

    // --- Reset state, BTB fill, alias, not-taken, stall ---
    tbl.push_back(rd(32'h0040_0100, 1'b0, 32'h0, 1'b0, 1'b0));
    tbl.push_back(rd(32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0));
    // Taken update at 0x400100. The same-cycle read still shows a miss.
    tbl.push_back(mk(OP_STEP, 1'b0, 1'b1, 1'b1, 32'h0040_0100, 32'h0040_0200, 32'h0040_0100,
                     1'b1, 1'b0, 32'h0, 1'b0, 1'b0));
    tbl.push_back(rd(32'h0040_0100, 1'b1, 32'h0040_0200, 1'b0, 1'b0));
    // GHR=1. Here 0x41^1 selects the trained gshare counter, and LHT[1]=0 selects the trained local counter.
    tbl.push_back(rd(32'h0040_0104, 1'b0, 32'h0, 1'b1, 1'b1));
    tbl.push_back(rd(32'h0080_0100, 1'b0, 32'h0, 1'b0, 1'b0));
    // Not-taken update with a different target. Neither the BTB entry nor its target may change.
    tbl.push_back(mk(OP_STEP, 1'b0, 1'b1, 1'b0, 32'h0040_0100, 32'hDEAD_BEE0, 32'h0040_0100,
                     1'b1, 1'b1, 32'h0040_0200, 1'b0, 1'b0));
    tbl.push_back(rd(32'h0040_0100, 1'b1, 32'h0040_0200, 1'b0, 1'b0));
    // A stalled taken branch must not train anything.
    tbl.push_back(mk(OP_STEP, 1'b1, 1'b1, 1'b1, 32'h0040_0300, 32'h1111_0000, 32'h0040_0300,
                     1'b1, 1'b0, 32'h0, 1'b0, 1'b0));
    tbl.push_back(rd(32'h0040_0300, 1'b0, 32'h0, 1'b0, 1'b0));
    // GHR must still be 2: 0x42^2 selects the counter trained to 2.
    tbl.push_back(rd(32'h0040_0108, 1'b0, 32'h0, 1'b1, 1'b1));

    // --- Clean restart, then saturate at 0x400040 ---
    tbl.push_back(mk(OP_RST, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
    for (int k = 1; k <= 11; k++) begin
      tbl.push_back(mk(OP_STEP, 1'b0, 1'b1, 1'b1, 32'h0040_0040, 32'h0040_0400, 32'h0040_0040,
                       1'b0, 1'b0, 32'h0, 1'b0, 1'b0));
      // After 9, 10 and 11 takens, both counters under the saturated histories must read as taken.
      // Any wrap of 3 -> 0 shows up at one of these points.
      if (k >= 9) tbl.push_back(rd(32'h0040_0040, 1'b1, 32'h0040_0400, 1'b1, 1'b1));
    end

    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // --- Asynchronous reset between edges: outputs drop without a clock ---
    @(negedge clk);
    idle();
    bif.if_pc_i = 32'h0040_0040;
    #1;
    cmp("pre_rst.hit", {31'h0, bif.btb_hit_o}, 32'h1);
    cmp("pre_rst.gbp", {31'h0, bif.gbp_pred_o}, 32'h1);
    cmp("pre_rst.lbp", {31'h0, bif.lbp_pred_o}, 32'h1);
    reset = 1'b0;
    #1;
    cmp("mid_rst.hit", {31'h0, bif.btb_hit_o}, 32'h0);
    cmp("mid_rst.gbp", {31'h0, bif.gbp_pred_o}, 32'h0);
    cmp("mid_rst.lbp", {31'h0, bif.lbp_pred_o}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // --- Two not-taken updates with GHR=0 and LHT=0 hit the same counters twice. No wrap below 0 ---
    run_vec(mk(OP_STEP, 1'b0, 1'b1, 1'b0, 32'h0040_0100, 32'h0040_0900, 32'h0040_0100,
               1'b1, 1'b0, 32'h0, 1'b0, 1'b0), 100);
    run_vec(mk(OP_STEP, 1'b0, 1'b1, 1'b0, 32'h0040_0100, 32'h0040_0900, 32'h0040_0100,
               1'b0, 1'b0, 32'h0, 1'b0, 1'b0), 101);
    run_vec(rd(32'h0040_0100, 1'b0, 32'h0, 1'b0, 1'b0), 102);
    run_vec(rd(32'h0040_0100, 1'b0, 32'h0, 1'b0, 1'b0), 103);

    if (sbq.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL sbq_drain: got %0d left, expected 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
